// File: rtl/ram_chk_pkg.sv
// ram_chk_pkg: FSM state type and expected read-back pattern for ram_rd_checker
package ram_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Callers truncate the result to their data width, giving seed + addr mod 2^DW
    function automatic logic [63:0] exp_pattern(input logic [63:0] seed, input logic [63:0] addr);
        return seed + addr;
    endfunction

endpackage

// File: rtl/rdchk_delay_line.sv
// rdchk_delay_line: DEPTH-deep valid/payload shift register aligning expected data with RAM read data
module rdchk_delay_line #(
    parameter int DEPTH = 1,
    parameter int PW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    input  logic [PW-1:0] push_data,
    output logic          tap_valid,
    output logic [PW-1:0] tap_data
);

    logic          vld [DEPTH];
    logic [PW-1:0] dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= push_valid;
            dat[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign tap_valid = vld[DEPTH-1];
    assign tap_data  = dat[DEPTH-1];

endmodule

// File: rtl/ram_rd_checker.sv
// ram_rd_checker: RAM read-back sweep checker; RDCHK_FIRST_ERR_EN enables first-mismatch address capture
module ram_rd_checker
    import ram_chk_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 16,
    parameter int RD_LAT = 1,
    parameter int ECW    = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [DW-1:0]  i_seed,
    output logic [AW-1:0]  o_addr,
    output logic           o_wr_en,
    output logic [DW-1:0]  o_wrdata,
    input  logic [DW-1:0]  i_rddata,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_pass,
    output logic [ECW-1:0] o_err_cnt,
    output logic [AW-1:0]  o_first_err_addr
);

    localparam int              CW         = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0]   DRAIN_LAST = CW'(RD_LAT - 1);
    localparam logic [AW-1:0]   LAST_ADDR  = '1;
    localparam logic [ECW-1:0]  ERR_MAX    = '1;
`ifdef RDCHK_FIRST_ERR_EN
    localparam int              PW         = DW + AW;
`else
    localparam int              PW         = DW;
`endif

    state_t          state, state_nx;
    logic [DW-1:0]   seed_q;
    logic [CW-1:0]   drain_cnt;
    logic            pass_q;
    logic            accept;
    logic            mism;
    logic [DW-1:0]   push_exp;
    logic [DW-1:0]   tap_exp;
    logic [PW-1:0]   push_data;
    logic [PW-1:0]   tap_data;
    logic            tap_valid;

    assign o_wr_en  = 1'b0;
    assign o_wrdata = '0;
    assign accept   = (state == ST_IDLE) && i_start;
    assign push_exp = DW'(exp_pattern(64'(seed_q), 64'(o_addr)));
    assign mism     = tap_valid && (i_rddata != tap_exp);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = i_start ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nx = (o_addr == LAST_ADDR) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_nx = (drain_cnt == DRAIN_LAST) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        o_busy = state != ST_IDLE;
        o_done = state == ST_DONE;
        o_pass = o_done ? (o_err_cnt == '0) : pass_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_addr    <= '0;
            seed_q    <= '0;
            drain_cnt <= '0;
            pass_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (accept) begin
                seed_q <= i_seed;
                o_addr <= '0;
                pass_q <= 1'b0;
            end
            if (state == ST_ISSUE && o_addr != LAST_ADDR)
                o_addr <= o_addr + 1'b1;
            if (state == ST_DONE)
                pass_q <= (o_err_cnt == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_err_cnt <= '0;
        else if (accept)
            o_err_cnt <= '0;
        else if (mism && o_err_cnt != ERR_MAX)
            o_err_cnt <= o_err_cnt + 1'b1;
    end

    rdchk_delay_line #(
        .DEPTH (RD_LAT),
        .PW    (PW)
    ) u_delay (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push_valid (state == ST_ISSUE),
        .push_data  (push_data),
        .tap_valid  (tap_valid),
        .tap_data   (tap_data)
    );

`ifdef RDCHK_FIRST_ERR_EN
    logic [AW-1:0] tap_addr;
    logic [AW-1:0] first_q;

    assign push_data            = {o_addr, push_exp};
    assign {tap_addr, tap_exp}  = tap_data;
    assign o_first_err_addr     = first_q;

    // A zero count marks the first mismatch, since the count only grows within a sweep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            first_q <= '0;
        else if (accept)
            first_q <= '0;
        else if (mism && o_err_cnt == '0)
            first_q <= tap_addr;
    end
`else
    assign push_data        = push_exp;
    assign tap_exp          = tap_data;
    assign o_first_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_rd_checker.sv
// tb_ram_rd_checker: randomized and directed read-back sweeps against a reference model, RD_LAT 1 and 3
module tb_ram_rd_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic [15:0] seed [2];
    logic [4:0]  addr [2];
    logic        wr_en [2];
    logic [15:0] wrdata [2];
    logic [15:0] rddata [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [4:0]  ferr [2];
    logic [7:0]  err0;
    logic [3:0]  err1;
    logic [15:0] mem [2][32];
    logic [15:0] q0;
    logic [15:0] q1 [3];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ram_rd_checker #(.AW(5), .DW(16), .RD_LAT(1), .ECW(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_seed(seed[0]),
        .o_addr(addr[0]), .o_wr_en(wr_en[0]), .o_wrdata(wrdata[0]), .i_rddata(rddata[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_err_cnt(err0),
        .o_first_err_addr(ferr[0])
    );

    ram_rd_checker #(.AW(5), .DW(16), .RD_LAT(3), .ECW(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_seed(seed[1]),
        .o_addr(addr[1]), .o_wr_en(wr_en[1]), .o_wrdata(wrdata[1]), .i_rddata(rddata[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_err_cnt(err1),
        .o_first_err_addr(ferr[1])
    );

    always @(posedge clk) begin
        q0    <= mem[0][addr[0]];
        q1[0] <= mem[1][addr[1]];
        q1[1] <= q1[0];
        q1[2] <= q1[1];
    end
    assign rddata[0] = q0;
    assign rddata[1] = q1[2];

    function automatic logic [7:0] err_of(input int u);
        return u != 0 ? {4'b0, err1} : err0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: clean pattern, 1: every word wrong, 2: random sparse corruption
    task automatic fill(input int u, input logic [15:0] s, input int mode);
        for (int a = 0; a < 32; a++) begin
            logic [15:0] w;
            w = 16'(s + a);
            if (mode == 1) w = ~w;
            if (mode == 2 && $urandom_range(0, 5) == 0) w = w ^ 16'($urandom_range(1, 65535));
            mem[u][a] = w;
        end
    endtask

    task automatic sweep(input int u, input logic [15:0] s, input int restart_at, input string tag);
        int lat, done_cyc, max_err, exp_err, exp_first, n_done, d_at, addr_bad, busy_bad;
        bit found;
        lat = (u != 0) ? 3 : 1;
        max_err = (u != 0) ? 15 : 255;
        done_cyc = 32 + lat + 1;
        exp_err = 0;
        exp_first = 0;
        found = 0;
        for (int a = 0; a < 32; a++) begin
            if (mem[u][a] !== 16'(s + a)) begin
                if (!found) exp_first = a;
                found = 1;
                exp_err++;
            end
        end
        if (exp_err > max_err) exp_err = max_err;
`ifndef RDCHK_FIRST_ERR_EN
        exp_first = 0;
`endif
        seed[u] = s;
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        seed[u] = ~s;
        n_done = 0;
        d_at = -1;
        addr_bad = 0;
        busy_bad = 0;
        for (int c = 1; c <= done_cyc + 5; c++) begin
            if (c <= 32 && addr[u] !== 5'(c - 1)) addr_bad++;
            if (c > 32 && addr[u] !== 5'd31) addr_bad++;
            if (busy[u] !== (c <= done_cyc)) busy_bad++;
            if (done[u] === 1'b1) begin
                n_done++;
                d_at = c;
                check({tag, "_pass_at_done"}, 32'(pass[u]), 32'(exp_err == 0));
                check({tag, "_err_at_done"}, 32'(err_of(u)), 32'(exp_err));
            end
            start[u] = (c == restart_at);
            @(negedge clk);
        end
        start[u] = 1'b0;
        check({tag, "_addr_seq"}, 32'(addr_bad), 0);
        check({tag, "_busy_seq"}, 32'(busy_bad), 0);
        check({tag, "_done_count"}, 32'(n_done), 1);
        check({tag, "_done_cycle"}, 32'(d_at), 32'(done_cyc));
        check({tag, "_pass_held"}, 32'(pass[u]), 32'(exp_err == 0));
        check({tag, "_err_held"}, 32'(err_of(u)), 32'(exp_err));
        check({tag, "_first_err"}, 32'(ferr[u]), 32'(exp_first));
        check({tag, "_wr_off"}, {15'b0, wr_en[u], wrdata[u]}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        seed[0] = '0;
        seed[1] = '0;
        fill(0, 16'h0, 0);
        fill(1, 16'h0, 0);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++)
            check($sformatf("reset_outs%0d", u),
                  {busy[u], done[u], pass[u], err_of(u), addr[u], ferr[u]}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(0, 16'h1000, 0);
        sweep(0, 16'h1000, -1, "clean");

        mem[0][7] = 16'hDEAD;
        sweep(0, 16'h1000, -1, "word7");

        fill(0, 16'hFFF0, 0);
        sweep(0, 16'hFFF0, -1, "wrap");

        fill(1, 16'h1234, 1);
        sweep(1, 16'h1234, -1, "sat_lat3");

        fill(1, 16'hFFF0, 0);
        sweep(1, 16'hFFF0, -1, "wrap_lat3");

        fill(0, 16'h4321, 0);
        mem[0][0] = 16'h0;
        mem[0][31] = 16'h0;
        sweep(0, 16'h4321, 10, "restart");

        begin
            int nd;
            fill(0, 16'h2222, 0);
            mem[0][3] = mem[0][3] ^ 16'h1;
            mem[0][5] = mem[0][5] ^ 16'h8;
            seed[0] = 16'h2222;
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            repeat (11) @(negedge clk);
            check("pre_reset_err", 32'(err0), 2);
            check("pre_reset_addr", 32'(addr[0]), 11);
            rst_n = 1'b0;
            #1;
            check("mid_reset_outs", {busy[0], done[0], pass[0], err0, addr[0], ferr[0]}, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            nd = 0;
            for (int c = 0; c < 50; c++) begin
                if (done[0] === 1'b1 || busy[0] !== 1'b0) nd++;
                @(negedge clk);
            end
            check("post_reset_quiet", 32'(nd), 0);
            check("post_reset_outs", {pass[0], err0, addr[0], ferr[0]}, 0);
        end
        sweep(0, 16'h2222, -1, "after_reset");

        for (int t = 0; t < 8; t++) begin
            int u;
            logic [15:0] s;
            u = $urandom_range(0, 1);
            s = 16'($urandom);
            fill(u, s, (t == 3) ? 1 : ((t == 0) ? 0 : 2));
            sweep(u, s, (t % 2 == 1) ? int'($urandom_range(2, 30)) : -1, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_rd_checker.md
RAM_RD_CHECKER -- requirements
Module: ram_rd_checker

Interface
REQ-001 Parameters SHALL be: AW, default 5, address width; DW, default 16, data width; RD_LAT, default 1, RAM read latency in clocks (1..4); ECW, default 8, error counter width.
REQ-002 i_clk  input  1  single clock; all logic rising-edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  one-cycle pulse that starts a read-back sweep.
REQ-005 i_seed  input  DW  pattern seed, sampled on accepted i_start.
REQ-006 o_addr  output  AW  RAM port address.
REQ-007 o_wr_en  output  1  RAM port write enable, constant 0.
REQ-008 o_wrdata  output  DW  RAM port write data, constant 0.
REQ-009 i_rddata  input  DW  RAM port read data, valid RD_LAT cycles after o_addr.
REQ-010 o_busy  output  1  sweep in progress.
REQ-011 o_done  output  1  one-cycle pulse when the sweep completes.
REQ-012 o_pass  output  1  result of the last sweep; 1 when zero mismatches.
REQ-013 o_err_cnt  output  ECW  mismatch count of the current or last sweep.
REQ-014 o_first_err_addr  output  AW  address of first mismatch (feature-dependent, see Configuration).

Function
REQ-015 Expected data for address A SHALL be (seed + A) modulo 2^DW, with A zero-extended to DW.
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: i_start SHALL latch the seed, clear o_err_cnt and o_pass, set o_addr=0 and go to ISSUE the next cycle.
REQ-018 ISSUE: o_addr SHALL increment by 1 each cycle, 0 to 2^AW-1 with no gaps; after issuing 2^AW-1 go to DRAIN.
REQ-019 DRAIN: hold for RD_LAT cycles until the last read returns, then go to DONE.
REQ-020 DONE: one cycle; o_done=1 and o_pass=(o_err_cnt==0); return to IDLE.
REQ-021 o_busy SHALL be 1 in ISSUE, DRAIN and DONE and 0 in IDLE.
REQ-022 A valid/expected-data pipeline of depth RD_LAT SHALL align each compare with its i_rddata; compare only when the aligned valid is 1.
REQ-023 Each mismatch SHALL increment o_err_cnt, which saturates at 2^ECW-1.
REQ-024 i_start while o_busy=1 SHALL be ignored.
REQ-025 o_addr SHALL hold its last value in DRAIN, DONE and IDLE.
REQ-026 Sweep length SHALL be exactly 2^AW issued reads; done-pulse latency from i_start is 2^AW+RD_LAT+1 cycles.

Reset
REQ-027 Assertion of i_rst_n=0 at any time, including mid-sweep, SHALL immediately force: state IDLE, o_addr=0, o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_first_err_addr=0, pipeline valids=0.
REQ-028 After deassertion the block SHALL wait for a new i_start; no partial result is reported.

Configuration
REQ-029 With macro RDCHK_FIRST_ERR_EN defined, o_first_err_addr SHALL capture the address of the first mismatch of a sweep and hold it until the next accepted i_start.
REQ-030 Without RDCHK_FIRST_ERR_EN, o_first_err_addr SHALL be constant 0 and no capture logic synthesized.

Structure
REQ-031 Package ram_chk_pkg SHALL hold the FSM state type, the state encodings and the expected-pattern function.
REQ-032 Sub-module rdchk_delay_line SHALL implement the RD_LAT-deep valid/expected/address shift register.

Verification
REQ-033 AW=5, RD_LAT=1, RAM pre-written with 0x1000+A, seed=0x1000, pulse start -> o_addr 0..31, o_done at cycle 34, o_pass=1, o_err_cnt=0.
REQ-034 Same, but RAM word 7 corrupted to 0xDEAD -> o_pass=0, o_err_cnt=1, o_first_err_addr=7 (macro defined), 0 (macro undefined).
REQ-035 Seed 0xFFF0, RAM holds (0xFFF0+A) mod 2^16 -> wrap at A=16 compares correctly, o_pass=1.
REQ-036 RD_LAT=3, all 32 words wrong, ECW=4 -> o_err_cnt saturates at 15, o_done at cycle 36.
REQ-037 i_start re-pulsed at cycle 10 of a sweep -> ignored, single o_done; i_rst_n low at cycle 12 -> all outputs 0, no o_done, new start completes normally.
